// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package instr_fetch_unit_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_FAULT = 2'd3
   } fetch_state_t;

   typedef logic [1:0] fault_cause_t;

   localparam fault_cause_t FC_NONE     = 2'd0;
   localparam fault_cause_t FC_MISALIGN = 2'd1;
   localparam fault_cause_t FC_BUSERR   = 2'd2;
   localparam fault_cause_t FC_TIMEOUT  = 2'd3;

   // Low two bits of every full-width (32-bit) encoding.
   localparam logic [1:0] OPC_LEN32 = 2'b11;

   function automatic logic is_len32(input logic [1:0] low_bits);
      return low_bits == OPC_LEN32;
   endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Control-side and memory-side signals of the fetch stage, bundled as one interface.
interface instr_fetch_unit_if #(
   parameter int ADDR_W  = 64,
   parameter int INSTR_W = 32
);
   import instr_fetch_unit_pkg::*;

   logic                fetch_req;
   logic [ADDR_W-1:0]   pc_in;
   logic                flush;
   logic                mem_req;
   logic [ADDR_W-1:0]   mem_addr;
   logic                mem_ack;
   logic                mem_err;
   logic [INSTR_W-1:0]  mem_rdata;
   logic [INSTR_W-1:0]  instruction_out;
   logic                instr_valid;
   logic                fetch_busy;
   logic                fetch_fault;
   fault_cause_t        fault_cause;

   // master: the fetch unit itself; slave: control FSM plus instruction memory.
   modport master (
      input  fetch_req, pc_in, flush, mem_ack, mem_err, mem_rdata,
      output mem_req, mem_addr, instruction_out, instr_valid,
             fetch_busy, fetch_fault, fault_cause
   );

   modport slave (
      output fetch_req, pc_in, flush, mem_ack, mem_err, mem_rdata,
      input  mem_req, mem_addr, instruction_out, instr_valid,
             fetch_busy, fetch_fault, fault_cause
   );

endinterface

// File: rtl/instr_fetch_unit_watchdog.sv
// Clear/enable cycle counter with terminal-count flag; shared by the WAIT and DRAIN states.
module fetch_watchdog #(
   parameter int TIMEOUT = 64
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (en_i) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign tc_o = (count_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/instr_fetch_unit.sv
// Multi-cycle instruction fetch: one req/ack memory transaction per fetch, with fault detection.
module instr_fetch_unit
   import instr_fetch_unit_pkg::*;
#(
   parameter int ADDR_W  = 64,
   parameter int INSTR_W = 32,
   parameter int TIMEOUT = 64
) (
   input  logic                clk,
   input  logic                reset,
   instr_fetch_unit_if.master  bus
);

   fetch_state_t        state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [INSTR_W-1:0]  instr_q, instr_d;
   logic                valid_q, valid_d;
   fault_cause_t        cause_q, cause_d;
   logic                wd_clr, wd_en, wd_tc;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      instr_d = instr_q;
      valid_d = 1'b0;
      cause_d = cause_q;

      unique case (state_q)
         ST_IDLE: begin
            if (bus.fetch_req) begin
               if (bus.pc_in[1:0] != 2'b00) begin
                  state_d = ST_FAULT;
                  cause_d = FC_MISALIGN;
               end else begin
                  addr_d  = bus.pc_in;
                  state_d = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            // A flush wins over everything; a coincident ack is simply dropped.
            if (bus.flush) begin
               state_d = bus.mem_ack ? ST_IDLE : ST_DRAIN;
            end else if (bus.mem_ack) begin
               if (bus.mem_err) begin
                  state_d = ST_FAULT;
                  cause_d = FC_BUSERR;
               end else if (is_len32(bus.mem_rdata[1:0])) begin
                  instr_d = bus.mem_rdata;
                  valid_d = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_FAULT;
                  cause_d = FC_TIMEOUT;
               end
            end else if (wd_tc) begin
               state_d = ST_FAULT;
               cause_d = FC_TIMEOUT;
            end
         end
         ST_DRAIN: begin
            if (bus.mem_ack || wd_tc) begin
               state_d = ST_IDLE;
            end
         end
         ST_FAULT: begin
            if (bus.flush) begin
               state_d = ST_IDLE;
               cause_d = FC_NONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      wd_clr = (state_d != state_q);
      wd_en  = (state_q == ST_WAIT) || (state_q == ST_DRAIN);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         instr_q <= '0;
         valid_q <= 1'b0;
         cause_q <= FC_NONE;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         instr_q <= instr_d;
         valid_q <= valid_d;
         cause_q <= cause_d;
      end
   end

   fetch_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk   (clk),
      .rst_n (reset),
      .clr_i (wd_clr),
      .en_i  (wd_en),
      .tc_o  (wd_tc)
   );

   // Outputs decode straight from registered state so reset clears them without a clock.
   assign bus.mem_req         = (state_q == ST_WAIT);
   assign bus.mem_addr        = addr_q;
   assign bus.instruction_out = instr_q;
   assign bus.instr_valid     = valid_q;
   assign bus.fetch_busy      = (state_q == ST_WAIT) || (state_q == ST_DRAIN);
   assign bus.fetch_fault     = (state_q == ST_FAULT);
   assign bus.fault_cause     = cause_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with TIMEOUT=8; each check is an immediate assertion.
module tb_instr_fetch_unit;

   localparam int ADDR_W  = 64;
   localparam int INSTR_W = 32;
   localparam int TIMEOUT = 8;

   logic clk;
   logic reset;
   int   checks   = 0;
   int   failures = 0;

   instr_fetch_unit_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus_if ();

   instr_fetch_unit #(
      .ADDR_W  (ADDR_W),
      .INSTR_W (INSTR_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_inputs();
      bus_if.fetch_req = 1'b0;
      bus_if.pc_in     = '0;
      bus_if.flush     = 1'b0;
      bus_if.mem_ack   = 1'b0;
      bus_if.mem_err   = 1'b0;
      bus_if.mem_rdata = '0;
   endtask

   task automatic issue_fetch(input logic [63:0] pc);
      bus_if.fetch_req = 1'b1;
      bus_if.pc_in     = pc;
      step();
      bus_if.fetch_req = 1'b0;
   endtask

   task automatic do_flush();
      bus_if.flush = 1'b1;
      step();
      bus_if.flush = 1'b0;
   endtask

   initial begin
      clear_inputs();
      reset = 1'b1;
      #2 reset = 1'b0;
      #1;
      chk("rst_mem_req", 64'(bus_if.mem_req), 64'd0);
      chk("rst_busy", 64'(bus_if.fetch_busy), 64'd0);
      chk("rst_fault", 64'(bus_if.fetch_fault), 64'd0);
      chk("rst_cause", 64'(bus_if.fault_cause), 64'd0);
      chk("rst_instr", 64'(bus_if.instruction_out), 64'd0);
      chk("rst_valid", 64'(bus_if.instr_valid), 64'd0);
      chk("rst_addr", bus_if.mem_addr, 64'd0);
      step();
      step();
      reset = 1'b1;
      step();
      $display("txn reset released");

      // Normal fetch, ack after three request cycles
      issue_fetch(64'h1000);
      chk("f1_mem_req_c1", 64'(bus_if.mem_req), 64'd1);
      chk("f1_mem_addr", bus_if.mem_addr, 64'h1000);
      chk("f1_busy", 64'(bus_if.fetch_busy), 64'd1);
      step();
      chk("f1_mem_req_c2", 64'(bus_if.mem_req), 64'd1);
      step();
      chk("f1_mem_req_c3", 64'(bus_if.mem_req), 64'd1);
      chk("f1_valid_early", 64'(bus_if.instr_valid), 64'd0);
      bus_if.mem_ack   = 1'b1;
      bus_if.mem_rdata = 32'h0050_0093;
      step();
      clear_inputs();
      chk("f1_valid", 64'(bus_if.instr_valid), 64'd1);
      chk("f1_instr", 64'(bus_if.instruction_out), 64'h0050_0093);
      chk("f1_mem_req_drop", 64'(bus_if.mem_req), 64'd0);
      chk("f1_busy_drop", 64'(bus_if.fetch_busy), 64'd0);
      step();
      chk("f1_valid_once", 64'(bus_if.instr_valid), 64'd0);
      $display("txn fetch pc=0x1000 instr=0x%08h", bus_if.instruction_out);

      // Misaligned PC
      issue_fetch(64'h1002);
      chk("mis_mem_req", 64'(bus_if.mem_req), 64'd0);
      chk("mis_fault", 64'(bus_if.fetch_fault), 64'd1);
      chk("mis_cause", 64'(bus_if.fault_cause), 64'd1);
      chk("mis_busy", 64'(bus_if.fetch_busy), 64'd0);
      issue_fetch(64'h3000);
      chk("mis_req_ignored", 64'(bus_if.mem_req), 64'd0);
      chk("mis_fault_held", 64'(bus_if.fault_cause), 64'd1);
      do_flush();
      chk("mis_flush_fault", 64'(bus_if.fetch_fault), 64'd0);
      chk("mis_flush_cause", 64'(bus_if.fault_cause), 64'd0);
      $display("txn misaligned pc=0x1002 cleared by flush");

      // Bus error
      issue_fetch(64'h1004);
      bus_if.mem_ack   = 1'b1;
      bus_if.mem_err   = 1'b1;
      bus_if.mem_rdata = 32'hFFFF_FFFF;
      step();
      clear_inputs();
      chk("berr_fault", 64'(bus_if.fetch_fault), 64'd1);
      chk("berr_cause", 64'(bus_if.fault_cause), 64'd2);
      chk("berr_instr_kept", 64'(bus_if.instruction_out), 64'h0050_0093);
      chk("berr_valid", 64'(bus_if.instr_valid), 64'd0);
      chk("berr_mem_req", 64'(bus_if.mem_req), 64'd0);
      do_flush();
      $display("txn bus error pc=0x1004");

      // Timeout: mem_req high for exactly TIMEOUT cycles
      issue_fetch(64'h1008);
      for (int i = 0; i < TIMEOUT; i++) begin
         chk($sformatf("to_mem_req_c%0d", i), 64'(bus_if.mem_req), 64'd1);
         step();
      end
      chk("to_mem_req_drop", 64'(bus_if.mem_req), 64'd0);
      chk("to_cause", 64'(bus_if.fault_cause), 64'd3);
      chk("to_fault", 64'(bus_if.fetch_fault), 64'd1);
      do_flush();
      $display("txn timeout pc=0x1008");

      // Compressed encoding
      issue_fetch(64'h100C);
      bus_if.mem_ack   = 1'b1;
      bus_if.mem_rdata = 32'h0000_4501;
      step();
      clear_inputs();
      chk("rvc_cause", 64'(bus_if.fault_cause), 64'd3);
      chk("rvc_instr_kept", 64'(bus_if.instruction_out), 64'h0050_0093);
      chk("rvc_valid", 64'(bus_if.instr_valid), 64'd0);
      do_flush();
      $display("txn compressed encoding pc=0x100c");

      // Flush in WAIT, orphan ack two cycles later
      issue_fetch(64'h1010);
      do_flush();
      chk("drn_mem_req", 64'(bus_if.mem_req), 64'd0);
      chk("drn_busy", 64'(bus_if.fetch_busy), 64'd1);
      step();
      chk("drn_busy_hold", 64'(bus_if.fetch_busy), 64'd1);
      bus_if.mem_ack   = 1'b1;
      bus_if.mem_rdata = 32'hDEAD_BEEF;
      step();
      clear_inputs();
      chk("drn_busy_clr", 64'(bus_if.fetch_busy), 64'd0);
      chk("drn_valid", 64'(bus_if.instr_valid), 64'd0);
      chk("drn_instr_kept", 64'(bus_if.instruction_out), 64'h0050_0093);
      $display("txn flush during wait, orphan ack discarded");

      // Minimum latency fetch at 0x2000
      issue_fetch(64'h2000);
      chk("min_mem_addr", bus_if.mem_addr, 64'h2000);
      chk("min_mem_req", 64'(bus_if.mem_req), 64'd1);
      bus_if.mem_ack   = 1'b1;
      bus_if.mem_rdata = 32'h00A0_0113;
      step();
      clear_inputs();
      chk("min_valid", 64'(bus_if.instr_valid), 64'd1);
      chk("min_instr", 64'(bus_if.instruction_out), 64'h00A0_0113);
      $display("txn fetch pc=0x2000 instr=0x%08h", bus_if.instruction_out);

      // Flush and ack in the same WAIT cycle
      issue_fetch(64'h2004);
      bus_if.flush     = 1'b1;
      bus_if.mem_ack   = 1'b1;
      bus_if.mem_rdata = 32'h1234_5673;
      step();
      clear_inputs();
      chk("fa_busy", 64'(bus_if.fetch_busy), 64'd0);
      chk("fa_valid", 64'(bus_if.instr_valid), 64'd0);
      chk("fa_instr_kept", 64'(bus_if.instruction_out), 64'h00A0_0113);
      chk("fa_fault", 64'(bus_if.fetch_fault), 64'd0);
      $display("txn flush with coincident ack pc=0x2004");

      // DRAIN leaves after TIMEOUT cycles without an ack
      issue_fetch(64'h2008);
      do_flush();
      for (int i = 1; i < TIMEOUT; i++) step();
      chk("drn_to_busy_hold", 64'(bus_if.fetch_busy), 64'd1);
      step();
      chk("drn_to_busy_clr", 64'(bus_if.fetch_busy), 64'd0);
      chk("drn_to_fault", 64'(bus_if.fetch_fault), 64'd0);
      $display("txn drain timeout pc=0x2008");

      // Stray ack in IDLE
      bus_if.mem_ack   = 1'b1;
      bus_if.mem_rdata = 32'hFFFF_FFFF;
      step();
      clear_inputs();
      chk("idle_ack_valid", 64'(bus_if.instr_valid), 64'd0);
      chk("idle_ack_instr", 64'(bus_if.instruction_out), 64'h00A0_0113);
      $display("txn stray ack in idle ignored");

      // Asynchronous reset in WAIT
      issue_fetch(64'h3000);
      chk("ar_pre_req", 64'(bus_if.mem_req), 64'd1);
      #2 reset = 1'b0;
      #1;
      chk("ar_mem_req", 64'(bus_if.mem_req), 64'd0);
      chk("ar_busy", 64'(bus_if.fetch_busy), 64'd0);
      chk("ar_instr", 64'(bus_if.instruction_out), 64'd0);
      step();
      reset = 1'b1;
      step();
      chk("ar_idle_busy", 64'(bus_if.fetch_busy), 64'd0);
      chk("ar_idle_req", 64'(bus_if.mem_req), 64'd0);
      issue_fetch(64'h3004);
      chk("ar_refetch_req", 64'(bus_if.mem_req), 64'd1);
      chk("ar_refetch_addr", bus_if.mem_addr, 64'h3004);
      bus_if.mem_ack   = 1'b1;
      bus_if.mem_rdata = 32'h0010_0073;
      step();
      clear_inputs();
      chk("ar_refetch_instr", 64'(bus_if.instruction_out), 64'h0010_0073);
      $display("txn async reset during wait, refetch pc=0x3004");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
